// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and RV32I funct3 size codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a raw bus word and sign/zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    ext = {{24{b[7]}}, b};
            F3_H:    ext = {{16{h[15]}}, h};
            F3_BU:   ext = {24'd0, b};
            F3_HU:   ext = {16'd0, h};
            F3_W:    ext = word;
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage data-memory controller: IDLE->REQ->WAIT->DONE valid/ready bus access with timeout.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e    state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [1:0]    off_n;
    logic [3:0]    be_n;
    logic [31:0]   wd_n;
    logic [31:0]   ext;
    logic          req_in;

    assign req_in = mem_rd | mem_wr;
    assign stall  = (state == IDLE && req_in) || state == REQ || state == WAIT;

    // Size comes from funct3[1:0]; the 011/110/111 codes fall into the word arm.
    always_comb begin
        off_n = 2'b00;
        be_n  = 4'b1111;
        wd_n  = wdata;
        case (funct3[1:0])
            2'b00: begin
                off_n = addr[1:0];
                be_n  = 4'b0001 << addr[1:0];
                wd_n  = {4{wdata[7:0]}};
            end
            2'b01: begin
                off_n = {addr[1], 1'b0};
                be_n  = 4'b0011 << {addr[1], 1'b0};
                wd_n  = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    logic misal_q;
    assign misal        = (funct3[1:0] == 2'b01) ? addr[0] :
                          (funct3[1:0] == 2'b00) ? 1'b0 : (addr[1:0] != 2'b00);
    assign misalign_err = misal_q;
`else
    assign misalign_err = 1'b0;
`endif

    load_extend u_ext (
        .word   (rsp_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .ext    (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            rdata     <= 32'd0;
            bus_err   <= 1'b0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 32'd0;
            req_be    <= 4'd0;
            req_wdata <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q   <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misal_q <= 1'b0;
`endif
            case (state)
                IDLE: if (req_in) begin
                    we_q  <= mem_wr;
                    f3_q  <= funct3;
                    off_q <= off_n;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misal) begin
                        misal_q <= 1'b1;
                        state   <= DONE;
                    end else
`endif
                    begin
                        req_valid <= 1'b1;
                        req_we    <= mem_wr;
                        req_addr  <= {addr[31:2], 2'b00};
                        req_be    <= be_n;
                        req_wdata <= wd_n;
                        state     <= REQ;
                    end
                end
                REQ: if (req_ready) begin
                    req_valid <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (!we_q) rdata <= ext;
                        state <= DONE;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        bus_err <= 1'b1;
                        if (!we_q) rdata <= 32'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
